// File: rtl/sext_pkg.sv
// Shared types and helpers for the sign-extension unpack sequencer.
package sext_pkg;

  typedef enum logic [1:0] {
    SEXT_W4,
    SEXT_W8,
    SEXT_W16,
    SEXT_WRSV
  } sext_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_UNPACK
  } sext_state_e;

  function automatic int unsigned fields_per_word(
    input sext_mode_e  mode,
    input int unsigned in_w
  );
    int unsigned n;
    unique case (1'b1)
      mode == SEXT_W4: n = in_w / 4;
      mode == SEXT_W8: n = in_w / 8;
      default:         n = in_w / 16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sext_field.sv
// Extracts the field at idx from a packed word and extends it.
// Reserved mode decodes as 16-bit fields.
module sext_field
  import sext_pkg::*;
#(
  parameter int InWordWidth = 32,
  parameter int OutputWidth = 16,
  parameter int IdxWidth    = 3
) (
  input  logic [InWordWidth-1:0] word,
  input  sext_mode_e             mode,
  input  logic [IdxWidth-1:0]    idx,
  input  logic                   zext,
  output logic [OutputWidth-1:0] data
);

  logic [InWordWidth-1:0] sh4;
  logic [InWordWidth-1:0] sh8;
  logic [InWordWidth-1:0] sh16;
  logic [3:0]             f4;
  logic [7:0]             f8;
  logic [15:0]            f16;

  assign sh4  = word >> {idx, 2'b00};
  assign sh8  = word >> {idx, 3'b000};
  assign sh16 = word >> {idx, 4'b0000};
  assign f4   = sh4[3:0];
  assign f8   = sh8[7:0];
  assign f16  = sh16[15:0];

  always_comb begin
    data = '0;
    unique case (1'b1)
      mode == SEXT_W4:
        if (zext) data = OutputWidth'(f4);
        else      data = OutputWidth'($signed(f4));
      mode == SEXT_W8:
        if (zext) data = OutputWidth'(f8);
        else      data = OutputWidth'($signed(f8));
      default:
        if (zext) data = OutputWidth'(f16);
        else      data = OutputWidth'($signed(f16));
    endcase
  end

endmodule

// File: rtl/sext_unpack_ctrl.sv
// Unpacks 4/8/16-bit signed fields from packed words, one per cycle.
// Define SEXT_ZERO_EXT_EN to add the cfg_unsigned zero-extension input.
module sext_unpack_ctrl
  import sext_pkg::*;
#(
  parameter int InWordWidth = 32,
  parameter int OutputWidth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cfg_mode,
`ifdef SEXT_ZERO_EXT_EN
  input  logic                   cfg_unsigned,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [InWordWidth-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OutputWidth-1:0] out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int MaxFields = InWordWidth / 4;
  localparam int IdxWidth  = $clog2(MaxFields);

  sext_state_e            state;
  sext_mode_e             mode_q;
  logic [IdxWidth-1:0]    idx;
  logic [IdxWidth-1:0]    last_idx;
  logic [InWordWidth-1:0] word_q;
  logic                   zext_q;
  logic                   zext_in;
  logic                   accept;

`ifdef SEXT_ZERO_EXT_EN
  assign zext_in = cfg_unsigned;
`else
  assign zext_in = 1'b0;
`endif

  assign last_idx  = IdxWidth'(fields_per_word(mode_q, InWordWidth) - 32'd1);
  assign out_valid = (state == ST_UNPACK);
  assign busy      = out_valid;
  assign out_last  = out_valid && (idx == last_idx);
  // Refill in the same cycle the final field leaves, so words chain without a bubble.
  assign in_ready  = (state == ST_IDLE) || (out_last && out_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      word_q <= '0;
      mode_q <= SEXT_W4;
      zext_q <= 1'b0;
    end else if (accept) begin
      state  <= ST_UNPACK;
      idx    <= '0;
      word_q <= in_data;
      mode_q <= sext_mode_e'(cfg_mode);
      zext_q <= zext_in;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  sext_field #(
    .InWordWidth(InWordWidth),
    .OutputWidth(OutputWidth),
    .IdxWidth   (IdxWidth)
  ) u_field (
    .word(word_q),
    .mode(mode_q),
    .idx (idx),
    .zext(zext_q),
    .data(out_data)
  );

endmodule

// File: tb/tb_sext_unpack_ctrl.sv
// Directed bench for sext_unpack_ctrl with hand-computed field values.
// Inputs change and outputs are sampled just after the falling edge.
module tb_sext_unpack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef SEXT_ZERO_EXT_EN
  logic        cfg_unsigned = 1'b0;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sext_unpack_ctrl #(
    .InWordWidth(32),
    .OutputWidth(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_mode    (cfg_mode),
`ifdef SEXT_ZERO_EXT_EN
    .cfg_unsigned(cfg_unsigned),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] d);
    in_valid = 1'b1;
    cfg_mode = m;
    in_data  = d;
    chk("acc_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic fld(input string tag, input logic [15:0] d,
                     input logic last);
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_d"}, 32'(out_data), 32'(d));
    chk({tag, "_l"}, 32'(out_last), 32'(last));
    chk({tag, "_r"}, 32'(in_ready), 32'(last));
    step();
  endtask

  task automatic idle(input string tag);
    chk({tag, "_v"}, 32'(out_valid), 32'd0);
    chk({tag, "_b"}, 32'(busy), 32'd0);
    chk({tag, "_r"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_mode  = 2'b00;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    idle("rst");
    chk("rst_l", 32'(out_last), 32'd0);
    rst = 1'b0;
    step();
    idle("post_rst");

    // mode 01, four 8-bit fields
    send(2'b01, 32'h80F77F01);
    fld("t1f0", 16'h0001, 1'b0);
    fld("t1f1", 16'h007F, 1'b0);
    fld("t1f2", 16'hFFF7, 1'b0);
    fld("t1f3", 16'hFF80, 1'b1);
    idle("t1_end");

    // mode 00, eight nibbles
    send(2'b00, 32'h000000F8);
    fld("t2f0", 16'hFFF8, 1'b0);
    fld("t2f1", 16'hFFFF, 1'b0);
    for (int i = 2; i < 8; i++)
      fld($sformatf("t2f%0d", i), 16'h0000, i == 7);
    idle("t2_end");

    send(2'b10, 32'h7FFF8000);
    fld("t2w0", 16'h8000, 1'b0);
    fld("t2w1", 16'h7FFF, 1'b1);
    send(2'b11, 32'h7FFF8000);
    fld("t2r0", 16'h8000, 1'b0);
    fld("t2r1", 16'h7FFF, 1'b1);
    idle("t2r_end");

    // backpressure at field 2
    send(2'b01, 32'h80F77F01);
    fld("t3f0", 16'h0001, 1'b0);
    fld("t3f1", 16'h007F, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3h_v", 32'(out_valid), 32'd1);
      chk("t3h_d", 32'(out_data), 32'h0000FFF7);
      chk("t3h_l", 32'(out_last), 32'd0);
      chk("t3h_r", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    fld("t3f2", 16'hFFF7, 1'b0);
    fld("t3f3", 16'hFF80, 1'b1);
    idle("t3_end");

    // back-to-back words with in_valid held
    in_valid = 1'b1;
    cfg_mode = 2'b01;
    in_data  = 32'h80F77F01;
    step();
    in_data  = 32'hFE7F8001;
    fld("t4a0", 16'h0001, 1'b0);
    fld("t4a1", 16'h007F, 1'b0);
    fld("t4a2", 16'hFFF7, 1'b0);
    fld("t4a3", 16'hFF80, 1'b1);
    in_valid = 1'b0;
    fld("t4b0", 16'h0001, 1'b0);
    fld("t4b1", 16'hFF80, 1'b0);
    fld("t4b2", 16'h007F, 1'b0);
    fld("t4b3", 16'hFFFE, 1'b1);
    idle("t4_end");

    // cfg_mode change mid-word
    send(2'b01, 32'h80F77F01);
    cfg_mode = 2'b00;
    fld("t5f0", 16'h0001, 1'b0);
    fld("t5f1", 16'h007F, 1'b0);
    fld("t5f2", 16'hFFF7, 1'b0);
    fld("t5f3", 16'hFF80, 1'b1);
    idle("t5_mid");
    send(2'b00, 32'h12345678);
    fld("t5n0", 16'hFFF8, 1'b0);
    fld("t5n1", 16'h0007, 1'b0);
    fld("t5n2", 16'h0006, 1'b0);
    fld("t5n3", 16'h0005, 1'b0);
    fld("t5n4", 16'h0004, 1'b0);
    fld("t5n5", 16'h0003, 1'b0);
    fld("t5n6", 16'h0002, 1'b0);
    fld("t5n7", 16'h0001, 1'b1);
    idle("t5_end");

    // reset mid-word drops it
    send(2'b01, 32'h80F77F01);
    fld("t6f0", 16'h0001, 1'b0);
    fld("t6f1", 16'h007F, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle("t6_rst");
    chk("t6_l", 32'(out_last), 32'd0);
    send(2'b01, 32'hFE7F8001);
    fld("t6n0", 16'h0001, 1'b0);
    fld("t6n1", 16'hFF80, 1'b0);
    fld("t6n2", 16'h007F, 1'b0);
    fld("t6n3", 16'hFFFE, 1'b1);
    idle("t6_end");

`ifdef SEXT_ZERO_EXT_EN
    cfg_unsigned = 1'b1;
    send(2'b01, 32'h80F77F01);
    cfg_unsigned = 1'b0;
    fld("z0", 16'h0001, 1'b0);
    fld("z1", 16'h007F, 1'b0);
    fld("z2", 16'h00F7, 1'b0);
    fld("z3", 16'h0080, 1'b1);
    idle("z_end");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
